branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
Fetch-stage direction and target predictor for the pipelined RV32I core, paired with the execute-stage branch resolution logic.
- Fetch: combinational lookup of pc_F gives a predicted next PC.
- Execute: the resolved outcome (taken/target) trains the tables. The block flags a mispredict and supplies the redirect PC that the hazard unit uses to flush IF/ID and ID/EX.
- Tables: direct-mapped BTB (valid/tag/target) plus a 2-bit saturating counter table.

Parameters:
INDEX_BITS, 6, log2 of table entries (64).
TAG_BITS, 8, BTB tag width taken from pc above the index.

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high reset
pc_F  input  32  fetch PC
predict_taken_F  output  1  predicted taken
predict_target_F  output  32  predicted next PC
pred_index_F  output  INDEX_BITS  counter index used; piped to EX
update_en_E  input  1  valid conditional branch or jal in EX, already qualified by the hazard unit (0 when stalled/flushed)
is_branch_E  input  1  1 = conditional branch, 0 = jal
taken_E  input  1  resolved direction (branch result; 1 for jal)
pc_E  input  32  PC of EX instruction
target_E  input  32  resolved target
pred_taken_E  input  1  prediction carried down the pipeline
pred_target_E  input  32  predicted target carried down the pipeline
pred_index_E  input  INDEX_BITS  pred_index_F carried down the pipeline
mispredict_E  output  1  flush request
redirect_pc_E  output  32  correct next PC on mispredict

Behaviour:
- Address fields: idx(pc) = pc[INDEX_BITS+1:2]; tag(pc) = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]; pc[1:0] is ignored.
- Lookup (combinational, zero latency):
  - hit = valid[idx(pc_F)] && tag match.
  - pred_index_F = idx(pc_F).
  - predict_taken_F = hit && cnt[pred_index_F][1].
  - predict_target_F = predict_taken_F ? btb_target : pc_F+4 (32-bit wrap).
- Resolution (combinational):
  - mispredict_E = update_en_E && (pred_taken_E != taken_E || (taken_E && pred_target_E != target_E)).
  - redirect_pc_E = taken_E ? target_E : pc_E+4.
  - Both are valid whenever update_en_E=1. When update_en_E=0, mispredict_E=0.
- Update (rising clk edge, only when update_en_E=1):
  - Counter cnt[pred_index_E], conditional branch: taken saturates up (max 11), not-taken saturates down (min 00).
  - Counter, jal: cnt[pred_index_E] is set to 11.
  - BTB hit at pc_E and taken_E=1: btb_target is overwritten with target_E.
  - BTB miss and taken_E=1: allocate with valid=1, tag=tag(pc_E), target=target_E. On allocation the counter is set to 10 (11 for jal), overriding the increment.
  - BTB miss and taken_E=0: no allocation; the counter still decrements.
  - BTB hit and taken_E=0: target unchanged.
- Read/write collision: fetch of the same index in the update cycle sees the pre-update contents. The new contents are visible the next cycle; there is no bypass.
- Reset (asynchronous, at any time including mid-update):
  - All valid bits clear and all counters go to 01 (weakly not-taken). Any in-flight update is discarded.
  - Outputs are combinational: during and after reset, predict_taken_F=0 and predict_target_F=pc_F+4.
- jalr is never presented (update_en_E=0); it is resolved by the existing EX redirect path.

Optional Feature:
BP_GSHARE_EN:
- Defined: adds an INDEX_BITS-wide global history register, reset to 0.
  - pred_index_F = idx(pc_F) XOR ghr.
  - On update_en_E && is_branch_E: ghr <= {ghr[INDEX_BITS-2:0], taken_E}. jal does not shift history.
  - History is non-speculative and changes only at EX resolution.
  - BTB valid/tag/target stay indexed by idx(pc).
- Undefined: no history register; pred_index_F = idx(pc_F).

Test Plan:
- Reset: assert reset, then pc_F=0x100 -> predict_taken_F=0, predict_target_F=0x104.
- Cold taken branch: update_en_E=1, is_branch_E=1, pc_E=0x100, taken_E=1, target_E=0x80, pred_taken_E=0 -> mispredict_E=1, redirect_pc_E=0x80. Next cycle pc_F=0x100 -> predict_taken_F=1, predict_target_F=0x80.
- Hysteresis: from counter 10, two more taken updates saturate at 11. First not-taken (pred_taken_E=1) -> mispredict_E=1, redirect 0x104, counter 10, still predicts taken. Second not-taken -> counter 01, pc_F=0x100 predicts 0x104.
- Alias: after allocating 0x100, pc_F=0x200 (same index, tag 0x02 vs 0x01) -> predict_taken_F=0, target 0x204. A taken jal at 0x200 to 0x300 replaces the entry; 0x100 then misses.
- Target change: pred_taken_E=1, pred_target_E=0x80, taken_E=1, target_E=0x90 -> mispredict_E=1, redirect 0x90. A later fetch of 0x100 predicts 0x90.
- Collision/reset: pc_F=0x100 in the same cycle as its allocating update -> not-taken that cycle, taken the next. Asserting reset mid-cycle clears the entry immediately -> predicts 0x104.

Source files
------------

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB plus 2-bit counter direction predictor with EX-stage training
// Optional global-history indexing of the counter table is enabled by defining BP_GSHARE_EN.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           pc_F,
  output logic                  predict_taken_F,
  output logic [31:0]           predict_target_F,
  output logic [INDEX_BITS-1:0] pred_index_F,
  input  logic                  update_en_E,
  input  logic                  is_branch_E,
  input  logic                  taken_E,
  input  logic [31:0]           pc_E,
  input  logic [31:0]           target_E,
  input  logic                  pred_taken_E,
  input  logic [31:0]           pred_target_E,
  input  logic [INDEX_BITS-1:0] pred_index_E,
  output logic                  mispredict_E,
  output logic [31:0]           redirect_pc_E
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic                valid   [ENTRIES];
  logic [TAG_BITS-1:0] tags    [ENTRIES];
  logic [31:0]         targets [ENTRIES];
  logic [1:0]          cnt     [ENTRIES];

  logic [INDEX_BITS-1:0] idx_F, idx_E;
  logic [TAG_BITS-1:0]   tag_F, tag_E;
  logic                  hit_F, hit_E;
  logic [1:0]            cnt_next;

  assign idx_F = pc_F[INDEX_BITS+1:2];
  assign idx_E = pc_E[INDEX_BITS+1:2];
  assign tag_F = pc_F[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign tag_E = pc_E[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign hit_F = valid[idx_F] && (tags[idx_F] == tag_F);
  assign hit_E = valid[idx_E] && (tags[idx_E] == tag_E);

`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr;

  // History is only advanced by resolved conditional branches, never speculatively.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr <= '0;
    end else if (update_en_E && is_branch_E) begin
      ghr <= {ghr[INDEX_BITS-2:0], taken_E};
    end
  end

  assign pred_index_F = idx_F ^ ghr;
`else
  assign pred_index_F = idx_F;
`endif

  assign predict_taken_F  = !reset && hit_F && cnt[pred_index_F][1];
  assign predict_target_F = predict_taken_F ? targets[idx_F] : pc_F + 32'd4;

  assign mispredict_E  = update_en_E &&
                         ((pred_taken_E != taken_E) || (taken_E && (pred_target_E != target_E)));
  assign redirect_pc_E = taken_E ? target_E : pc_E + 32'd4;

  // A fresh allocation overrides the normal saturating step.
  always_comb begin
    cnt_next = cnt[pred_index_E];
    if (taken_E && !hit_E) begin
      cnt_next = is_branch_E ? 2'b10 : 2'b11;
    end else if (!is_branch_E) begin
      cnt_next = 2'b11;
    end else if (taken_E) begin
      if (cnt_next != 2'b11) cnt_next = cnt_next + 2'd1;
    end else begin
      if (cnt_next != 2'b00) cnt_next = cnt_next - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        cnt[i]   <= 2'b01;
      end
    end else if (update_en_E) begin
      cnt[pred_index_E] <= cnt_next;
      if (taken_E) valid[idx_E] <= 1'b1;
    end
  end

  // Tag/target need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (update_en_E && taken_E) begin
      tags[idx_E]    <= tag_E;
      targets[idx_E] <= target_E;
    end
  end

endmodule
